// File: rtl/fpu8_nan_gate.sv
// ============================================================================
// Module   : fpu8_nan_gate
// Brief    : Two-stage valid/ready FP8 (E5M2) operand intake that classifies
//            NaN operands and short-circuits them with a propagated quiet NaN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu8_check_nan (
    input  logic [7:0] i_x,
    output logic       o_is_nan,
    output logic       o_qs_nan
);
    // E5M2: all-ones exponent with a non-zero mantissa; mantissa MSB marks quiet
    assign o_is_nan = (i_x[6:2] == 5'h1f) && (i_x[1:0] != 2'b00);
    assign o_qs_nan = i_x[1];
endmodule

module fpu8_nan_gate #(
    parameter int OPW   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_a,
    output logic [7:0]       out_b,
    output logic [OPW-1:0]   out_op,
    output logic             out_bypass,
    output logic [7:0]       out_result,
    output logic             out_inv,
    input  logic             clr_flags,
    output logic             sticky_inv,
    output logic [CNT_W-1:0] nan_cnt
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [7:0]       C_QUIET   = 8'h02;

    logic w_nan_a, w_qs_a, w_nan_b, w_qs_b;

    fpu8_check_nan u_check_a (.i_x(in_a), .o_is_nan(w_nan_a), .o_qs_nan(w_qs_a));
    fpu8_check_nan u_check_b (.i_x(in_b), .o_is_nan(w_nan_b), .o_qs_nan(w_qs_b));

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic             s1_nan_a_q, s1_nan_a_d, s1_qs_a_q, s1_qs_a_d;
    logic             s1_nan_b_q, s1_nan_b_d, s1_qs_b_q, s1_qs_b_d;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_a_q, out_a_d, out_b_q, out_b_d;
    logic [OPW-1:0]   out_op_q, out_op_d;
    logic             out_bypass_q, out_bypass_d;
    logic [7:0]       out_result_q, out_result_d;
    logic             out_inv_q, out_inv_d;
    logic             sticky_inv_q, sticky_inv_d;
    logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

    logic w_s2_adv, w_s1_adv, w_in_xfer, w_out_xfer;
    logic w_snan_a, w_snan_b;
    logic [CNT_W-1:0] w_cnt_base;

    assign w_s2_adv   = !out_valid_q || out_ready;
    assign w_s1_adv   = s1_valid_q && w_s2_adv;
    assign in_ready   = !s1_valid_q || w_s2_adv;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid_q && out_ready;

    assign w_snan_a = s1_nan_a_q && !s1_qs_a_q;
    assign w_snan_b = s1_nan_b_q && !s1_qs_b_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_nan_a_d = s1_nan_a_q;
        s1_qs_a_d  = s1_qs_a_q;
        s1_nan_b_d = s1_nan_b_q;
        s1_qs_b_d  = s1_qs_b_q;

        if (w_in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = in_op;
            s1_nan_a_d = w_nan_a;
            s1_qs_a_d  = w_qs_a;
            s1_nan_b_d = w_nan_b;
            s1_qs_b_d  = w_qs_b;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_op_d     = out_op_q;
        out_bypass_d = out_bypass_q;
        out_result_d = out_result_q;
        out_inv_d    = out_inv_q;

        if (w_s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (w_s1_adv) begin
            out_a_d      = s1_a_q;
            out_b_d      = s1_b_q;
            out_op_d     = s1_op_q;
            out_bypass_d = s1_nan_a_q || s1_nan_b_q;
            out_inv_d    = w_snan_a || w_snan_b;
            // Signalling operands win over quiet ones, A over B
            if (w_snan_a) begin
                out_result_d = s1_a_q | C_QUIET;
            end else if (w_snan_b) begin
                out_result_d = s1_b_q | C_QUIET;
            end else if (s1_nan_a_q) begin
                out_result_d = s1_a_q;
            end else if (s1_nan_b_q) begin
                out_result_d = s1_b_q;
            end else begin
                out_result_d = 8'h00;
            end
        end
    end

    // Clear is applied before the coinciding transfer's contribution
    always_comb begin
        w_cnt_base   = clr_flags ? '0 : nan_cnt_q;
        sticky_inv_d = (clr_flags ? 1'b0 : sticky_inv_q) || (w_out_xfer && out_inv_q);
        nan_cnt_d    = w_cnt_base;
        if (w_out_xfer && out_bypass_q && (w_cnt_base != C_CNT_MAX)) begin
            nan_cnt_d = w_cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= 8'h00;
            s1_b_q       <= 8'h00;
            s1_op_q      <= '0;
            s1_nan_a_q   <= 1'b0;
            s1_qs_a_q    <= 1'b0;
            s1_nan_b_q   <= 1'b0;
            s1_qs_b_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_a_q      <= 8'h00;
            out_b_q      <= 8'h00;
            out_op_q     <= '0;
            out_bypass_q <= 1'b0;
            out_result_q <= 8'h00;
            out_inv_q    <= 1'b0;
            sticky_inv_q <= 1'b0;
            nan_cnt_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_nan_a_q   <= s1_nan_a_d;
            s1_qs_a_q    <= s1_qs_a_d;
            s1_nan_b_q   <= s1_nan_b_d;
            s1_qs_b_q    <= s1_qs_b_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_op_q     <= out_op_d;
            out_bypass_q <= out_bypass_d;
            out_result_q <= out_result_d;
            out_inv_q    <= out_inv_d;
            sticky_inv_q <= sticky_inv_d;
            nan_cnt_q    <= nan_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_op     = out_op_q;
    assign out_bypass = out_bypass_q;
    assign out_result = out_result_q;
    assign out_inv    = out_inv_q;
    assign sticky_inv = sticky_inv_q;
    assign nan_cnt    = nan_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu8_nan_gate.sv
// ============================================================================
// Module   : tb_fpu8_nan_gate
// Brief    : Scoreboard bench for fpu8_nan_gate (E5M2 NaN intake pipeline).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu8_nan_gate;
    localparam int OPW   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a, in_b;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_a, out_b;
    logic [OPW-1:0]   out_op;
    logic             out_bypass;
    logic [7:0]       out_result;
    logic             out_inv;
    logic             clr_flags;
    logic             sticky_inv;
    logic [CNT_W-1:0] nan_cnt;

    fpu8_nan_gate #(.OPW(OPW), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .out_bypass(out_bypass), .out_result(out_result), .out_inv(out_inv),
        .clr_flags(clr_flags), .sticky_inv(sticky_inv), .nan_cnt(nan_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]     a;
        logic [7:0]     b;
        logic [OPW-1:0] op;
        logic           bypass;
        logic [7:0]     result;
        logic           inv;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic             m_sticky;
    logic [CNT_W-1:0] m_cnt;
    logic             prev_stall;
    logic [31:0]      prev_snap;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference classification straight from the E5M2 encoding
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [OPW-1:0] op);
        exp_t e;
        logic na, nb, sa, sb_;
        na  = (a[6:2] == 5'h1f) && (a[1:0] != 2'b00);
        nb  = (b[6:2] == 5'h1f) && (b[1:0] != 2'b00);
        sa  = na && (a[1:0] == 2'b01);
        sb_ = nb && (b[1:0] == 2'b01);
        e.a = a; e.b = b; e.op = op;
        e.bypass = na || nb;
        e.inv    = sa || sb_;
        if (sa)       e.result = {a[7:2], 2'b11};
        else if (sb_) e.result = {b[7:2], 2'b11};
        else if (na)  e.result = a;
        else if (nb)  e.result = b;
        else          e.result = 8'h00;
        return e;
    endfunction

    // Monitor: all sampling on the falling edge, inputs change just after rising edges
    always @(negedge clk) begin
        exp_t e;
        logic [CNT_W-1:0] base;
        logic [31:0] snap;
        snap = {out_valid, out_a, out_b, out_op, out_bypass, out_result, out_inv, 3'b000};
        if (rst) begin
            sb.delete();
            m_sticky   = 1'b0;
            m_cnt      = '0;
            prev_stall = 1'b0;
        end else begin
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == 2 && !out_ready)});
            if (sb.size() == 0) check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
            if (prev_stall) check_eq("stall_stable", snap, prev_snap);
            check_eq("sticky_inv", {31'd0, sticky_inv}, {31'd0, m_sticky});
            check_eq("nan_cnt", {24'd0, nan_cnt}, {24'd0, m_cnt});
            base     = clr_flags ? '0 : m_cnt;
            m_sticky = clr_flags ? 1'b0 : m_sticky;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_a", {24'd0, out_a}, {24'd0, e.a});
                    check_eq("out_b", {24'd0, out_b}, {24'd0, e.b});
                    check_eq("out_op", {30'd0, out_op}, {30'd0, e.op});
                    check_eq("out_bypass", {31'd0, out_bypass}, {31'd0, e.bypass});
                    check_eq("out_result", {24'd0, out_result}, {24'd0, e.result});
                    check_eq("out_inv", {31'd0, out_inv}, {31'd0, e.inv});
                    m_sticky = m_sticky | e.inv;
                    if (e.bypass && base != 8'hff) base = base + 1'b1;
                end
            end
            m_cnt = base;
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_op));
            prev_stall = out_valid && !out_ready;
            prev_snap  = snap;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [OPW-1:0] op);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check_eq("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("drain_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic timed_send(input logic [7:0] a, input logic [7:0] b);
        int cyc;
        send(a, b, 2'd1);
        idle();
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        check_eq("latency", cyc, 32'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b1; clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {out_a, out_b, out_result, 6'd0, out_op}, 32'd0);
        check_eq("rst_flags", {22'd0, out_bypass, out_inv, nan_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ordinary operands, then signalling / quiet NaN priority cases
        timed_send(8'h38, 8'h40);
        drain();
        send(8'h7D, 8'h38, 2'd2);
        send(8'h38, 8'h7E, 2'd3);
        send(8'h7E, 8'hFD, 2'd0);
        send(8'h7D, 8'hFD, 2'd1);
        send(8'hFE, 8'h7D, 2'd2);
        send(8'h7C, 8'hFC, 2'd3);
        idle();
        drain();

        // Back-to-back burst while downstream stalls for three cycles
        fork
            begin
                send(8'h11, 8'h22, 2'd0);
                send(8'h7F, 8'h33, 2'd1);
                send(8'h44, 8'h7D, 2'd2);
                send(8'h55, 8'h66, 2'd3);
                idle();
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Counter saturation, then a clear that coincides with a NaN transfer
        for (int i = 0; i < 260; i++) send(8'h7E, 8'(i), 2'(i));
        idle();
        drain();
        @(negedge clk);
        check_eq("cnt_saturated", {24'd0, nan_cnt}, 32'd255);
        @(posedge clk); #1;
        send(8'h7D, 8'h38, 2'd0);
        idle();
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        @(negedge clk);
        check_eq("clr_cnt", {24'd0, nan_cnt}, 32'd1);
        check_eq("clr_sticky", {31'd0, sticky_inv}, 32'd1);
        drain();

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(8'h7D, 8'h01, 2'd1);
        send(8'h02, 8'h7E, 2'd2);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_flags", {23'd0, sticky_inv, nan_cnt}, 32'd0);
        @(posedge clk); #1;
        timed_send(8'hFD, 8'h40);
        drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
